// File: rtl/bht_pkg.sv
// Shared types and constants for the two-bit branch history table.
// Counter encodings, table geometry and the update FSM states.
package bht_pkg;

  localparam int CTR_W   = 2;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
  localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
  localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
  localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/bht_sat_next.sv
// Saturating next value of a 2-bit branch counter.
// Shared with the predictor training path.
module bht_sat_next
  import bht_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (1'b1)
      (taken_i && ctr_i != CTR_ST):
        ctr_o = ctr_i + 2'd1;
      (!taken_i && ctr_i != CTR_SNT):
        ctr_o = ctr_i - 2'd1;
      default:
        ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/bht_counter_update.sv
// Write side of the 2-bit predictor: counter table, two-stage
// update pipeline, sweeping table clear and mispredict statistic.
module bht_counter_update #(
  parameter int         ENTRIES  = 16,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             clear,
  output logic             clear_busy,
  output logic [1:0]       ctr0,
  output logic [1:0]       ctr1,
  output logic [1:0]       ctr2,
  output logic [1:0]       ctr3,
  output logic [1:0]       ctr4,
  output logic [1:0]       ctr5,
  output logic [1:0]       ctr6,
  output logic [1:0]       ctr7,
  output logic [1:0]       ctr8,
  output logic [1:0]       ctr9,
  output logic [1:0]       ctr10,
  output logic [1:0]       ctr11,
  output logic [1:0]       ctr12,
  output logic [1:0]       ctr13,
  output logic [1:0]       ctr14,
  output logic [1:0]       ctr15,
  output logic             upd_done,
  output logic             upd_mispredict,
  output logic [15:0]      mis_cnt
);

  import bht_pkg::*;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             a_valid_q, a_valid_d;
  logic [IDX_W-1:0] a_idx_q, a_idx_d;
  logic             a_taken_q, a_taken_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       ctr_q [ENTRIES];
  logic [1:0]       ctr_d [ENTRIES];

  logic       accept;
  logic       clear_go;
  logic       wr_en;
  logic [1:0] old_ctr;
  logic [1:0] new_ctr;

  assign upd_ready = (state_q == ST_RUN) && !clear && !rst;
  assign accept    = upd_valid && upd_ready;
  assign clear_go  = (state_q == ST_RUN) && clear;
  assign wr_en     = a_valid_q && !clear_go;
  assign old_ctr   = ctr_q[a_idx_q];

  bht_sat_next u_sat (
    .ctr_i   (old_ctr),
    .taken_i (a_taken_q),
    .ctr_o   (new_ctr)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ctr_d     = ctr_q;
    cnt_d     = cnt_q;
    a_valid_d = accept;
    a_idx_d   = upd_idx;
    a_taken_d = upd_taken;
    done_d    = accept;
    mis_d     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
        if (wr_en) begin
          ctr_d[a_idx_q] = new_ctr;
          if (mis_q && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CLEAR: begin
        ctr_d[ptr_q] = INIT_CTR;
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == '0)
          cnt_d = '0;
        if (ptr_q == IDX_W'(ENTRIES - 1))
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Old MSB as stage B will see it, i.e. after this cycle's write
    if (accept)
      mis_d = ctr_d[upd_idx][1] != upd_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ptr_q     <= '0;
      a_valid_q <= 1'b0;
      a_idx_q   <= '0;
      a_taken_q <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= INIT_CTR;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_valid_q <= a_valid_d;
      a_idx_q   <= a_idx_d;
      a_taken_q <= a_taken_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      cnt_q     <= cnt_d;
      ctr_q     <= ctr_d;
    end
  end

  assign clear_busy     = (state_q == ST_CLEAR);
  assign upd_done       = done_q;
  assign upd_mispredict = mis_q;
  assign mis_cnt        = cnt_q;

  assign ctr0  = ctr_q[0];
  assign ctr1  = ctr_q[1];
  assign ctr2  = ctr_q[2];
  assign ctr3  = ctr_q[3];
  assign ctr4  = ctr_q[4];
  assign ctr5  = ctr_q[5];
  assign ctr6  = ctr_q[6];
  assign ctr7  = ctr_q[7];
  assign ctr8  = ctr_q[8];
  assign ctr9  = ctr_q[9];
  assign ctr10 = ctr_q[10];
  assign ctr11 = ctr_q[11];
  assign ctr12 = ctr_q[12];
  assign ctr13 = ctr_q[13];
  assign ctr14 = ctr_q[14];
  assign ctr15 = ctr_q[15];

endmodule

// File: tb/tb_bht_counter_update.sv
// Directed bench for bht_counter_update: saturation, full-rate
// updates, clear sweep, statistic saturation and reset mid-sweep.
module tb_bht_counter_update;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic        clear;
  logic        clear_busy;
  logic        upd_done;
  logic        upd_mispredict;
  logic [15:0] mis_cnt;
  logic [1:0]  ctr [16];

  int total;
  int passed;

  bht_counter_update dut (
    .clk            (clk),
    .rst            (rst),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .clear          (clear),
    .clear_busy     (clear_busy),
    .ctr0           (ctr[0]),
    .ctr1           (ctr[1]),
    .ctr2           (ctr[2]),
    .ctr3           (ctr[3]),
    .ctr4           (ctr[4]),
    .ctr5           (ctr[5]),
    .ctr6           (ctr[6]),
    .ctr7           (ctr[7]),
    .ctr8           (ctr[8]),
    .ctr9           (ctr[9]),
    .ctr10          (ctr[10]),
    .ctr11          (ctr[11]),
    .ctr12          (ctr[12]),
    .ctr13          (ctr[13]),
    .ctr14          (ctr[14]),
    .ctr15          (ctr[15]),
    .upd_done       (upd_done),
    .upd_mispredict (upd_mispredict),
    .mis_cnt        (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (ctr[i] !== 2'b01) bad++;
    total++;
    if (bad != 0) $display("FAIL reset_ctr: %0d entries not 01", bad);
    else passed++;
    total++;
    if (upd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", upd_ready);
    else passed++;
    total++;
    if ({upd_done, upd_mispredict, clear_busy} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000",
               {upd_done, upd_mispredict, clear_busy});
    else passed++;
    total++;
    if (mis_cnt !== 16'd0) $display("FAIL reset_mis_cnt: got %h want 0", mis_cnt);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (upd_ready !== 1'b1) $display("FAIL ready_after_rst: got %b want 1", upd_ready);
    else passed++;
  endtask

  task automatic test_taken_sat;
    logic [1:0] e [5];
    logic       ed [5];
    logic       em [5];
    e  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    ed = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    em = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    upd_valid = 1'b1;
    upd_idx   = 4'd3;
    upd_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) upd_valid = 1'b0;
      total++;
      if (ctr[3] !== e[i]) $display("FAIL taken_ctr3[%0d]: got %b want %b", i, ctr[3], e[i]);
      else passed++;
      total++;
      if (upd_done !== ed[i]) $display("FAIL taken_done[%0d]: got %b want %b", i, upd_done, ed[i]);
      else passed++;
      total++;
      if (upd_done && upd_mispredict !== em[i])
        $display("FAIL taken_mis[%0d]: got %b want %b", i, upd_mispredict, em[i]);
      else passed++;
    end
    tick();
    total++;
    if (mis_cnt !== 16'd1) $display("FAIL taken_mis_cnt: got %0d want 1", mis_cnt);
    else passed++;
  endtask

  task automatic test_nt_sat;
    int n;
    int bad;
    n = 0;
    upd_valid = 1'b1;
    upd_idx   = 4'd15;
    upd_taken = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) upd_valid = 1'b0;
      if (upd_done === 1'b1) n++;
      total++;
      if (upd_done && upd_mispredict !== 1'b0)
        $display("FAIL nt_mis[%0d]: got %b want 0", i, upd_mispredict);
      else passed++;
    end
    total++;
    if (n != 3) $display("FAIL nt_done_count: got %0d want 3", n);
    else passed++;
    total++;
    if (ctr[15] !== 2'b00) $display("FAIL nt_ctr15: got %b want 00", ctr[15]);
    else passed++;
    bad = 0;
    for (int i = 0; i < 15; i++)
      if (ctr[i] !== ((i == 3) ? 2'b11 : 2'b01)) bad++;
    total++;
    if (bad != 0) $display("FAIL nt_others: %0d entries changed", bad);
    else passed++;
    total++;
    if (mis_cnt !== 16'd1) $display("FAIL nt_mis_cnt: got %0d want 1", mis_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int n;
    n = 0;
    upd_valid = 1'b1;
    upd_taken = 1'b1;
    for (int i = 0; i < 8; i++) begin
      upd_idx = (i % 2 == 0) ? 4'd5 : 4'd6;
      #1;
      total++;
      if (upd_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, upd_ready);
      else passed++;
      tick();
      if (upd_done === 1'b1) n++;
    end
    upd_valid = 1'b0;
    tick();
    if (upd_done === 1'b1) n++;
    tick();
    total++;
    if (n != 8) $display("FAIL b2b_done_count: got %0d want 8", n);
    else passed++;
    total++;
    if ({ctr[5], ctr[6]} !== 4'b1111)
      $display("FAIL b2b_ctrs: got %b want 1111", {ctr[5], ctr[6]});
    else passed++;
    total++;
    if (mis_cnt !== 16'd3) $display("FAIL b2b_mis_cnt: got %0d want 3", mis_cnt);
    else passed++;
  endtask

  task automatic test_clear_collision;
    int bad;
    upd_valid = 1'b1;
    upd_idx   = 4'd2;
    upd_taken = 1'b1;
    tick();
    clear   = 1'b1;
    upd_idx = 4'd0;
    #1;
    total++;
    if (upd_ready !== 1'b0) $display("FAIL clr_ready_n: got %b want 0", upd_ready);
    else passed++;
    tick();
    clear     = 1'b0;
    upd_valid = 1'b0;
    total++;
    if (clear_busy !== 1'b1) $display("FAIL clr_busy_n1: got %b want 1", clear_busy);
    else passed++;
    total++;
    if (upd_done !== 1'b0) $display("FAIL clr_done_n1: got %b want 0", upd_done);
    else passed++;
    total++;
    if (ctr[2] !== 2'b01) $display("FAIL clr_ctr2_n1: got %b want 01", ctr[2]);
    else passed++;
    for (int k = 2; k <= 16; k++) begin
      tick();
      clear = (k == 5);
      #1;
      if (k == 16) begin
        total++;
        if ({clear_busy, upd_ready} !== 2'b10)
          $display("FAIL clr_n16: busy,ready got %b want 10", {clear_busy, upd_ready});
        else passed++;
      end
    end
    tick();
    total++;
    if ({clear_busy, upd_ready} !== 2'b01)
      $display("FAIL clr_n17: busy,ready got %b want 01", {clear_busy, upd_ready});
    else passed++;
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (ctr[i] !== 2'b01) bad++;
    total++;
    if (bad != 0) $display("FAIL clr_all_01: %0d entries not 01", bad);
    else passed++;
    total++;
    if (mis_cnt !== 16'd0) $display("FAIL clr_mis_cnt: got %0d want 0", mis_cnt);
    else passed++;
  endtask

  task automatic test_mis_sat;
    upd_valid = 1'b1;
    upd_idx   = 4'd7;
    for (int i = 0; i < 65535; i++) begin
      upd_taken = (i % 2 == 0);
      tick();
    end
    upd_valid = 1'b0;
    tick();
    tick();
    total++;
    if (mis_cnt !== 16'hFFFF) $display("FAIL mis_reach_max: got %h want ffff", mis_cnt);
    else passed++;
    total++;
    if (ctr[7] !== 2'b10) $display("FAIL mis_ctr7: got %b want 10", ctr[7]);
    else passed++;
    upd_valid = 1'b1;
    upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    total++;
    if ({upd_done, upd_mispredict} !== 2'b11)
      $display("FAIL mis_extra: done,mis got %b want 11", {upd_done, upd_mispredict});
    else passed++;
    tick();
    tick();
    total++;
    if (mis_cnt !== 16'hFFFF) $display("FAIL mis_hold_max: got %h want ffff", mis_cnt);
    else passed++;
    total++;
    if (ctr[7] !== 2'b01) $display("FAIL mis_ctr7_end: got %b want 01", ctr[7]);
    else passed++;
  endtask

  task automatic test_rst_mid_sweep;
    int bad;
    upd_valid = 1'b1;
    upd_idx   = 4'd9;
    upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if ({clear_busy, ctr[9]} !== 3'b110)
      $display("FAIL sweep7_state: busy,ctr9 got %b want 110", {clear_busy, ctr[9]});
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (upd_ready !== 1'b0) $display("FAIL rst_ready_low: got %b want 0", upd_ready);
    else passed++;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({clear_busy, upd_ready, upd_done} !== 3'b010)
      $display("FAIL rst_sweep: busy,ready,done got %b want 010",
               {clear_busy, upd_ready, upd_done});
    else passed++;
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (ctr[i] !== 2'b01) bad++;
    total++;
    if (bad != 0) $display("FAIL rst_sweep_ctrs: %0d entries not 01", bad);
    else passed++;
    total++;
    if (mis_cnt !== 16'd0) $display("FAIL rst_sweep_mis: got %h want 0", mis_cnt);
    else passed++;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    upd_valid = 1'b0;
    upd_idx   = 4'd0;
    upd_taken = 1'b0;
    clear     = 1'b0;
    test_reset();
    test_taken_sat();
    test_nt_sat();
    test_back_to_back();
    test_clear_collision();
    test_mis_sat();
    test_rst_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bht_counter_update.md
# bht_counter_update

Write side of the two-bit dynamic branch predictor. The block holds the 16-entry table of 2-bit saturating counters and applies resolved-branch outcomes through a two-stage update pipeline. It drives all 16 counters in parallel to the predictor's 16:1 read multiplexer, `ip0`..`ip15`. It also provides a multi-cycle table clear and a saturating mispredict statistic.

## Interface
Parameters:
- `ENTRIES`, 16: table depth; fixed by the 16-way read mux.
- `IDX_W`, 4: index width; log2(ENTRIES).
- `INIT_CTR`, 2'b01: counter value after reset or clear (weakly not-taken).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `upd_valid` in 1: resolved-branch update request.
- `upd_ready` out 1: block can accept an update this cycle.
- `upd_idx` in IDX_W: table entry to update.
- `upd_taken` in 1: resolved outcome; 1 = taken.
- `clear` in 1: request to reinitialise the whole table.
- `clear_busy` out 1: clear sweep in progress.
- `ctr0`..`ctr15` out 2 each: current counter values, registered, to mux `ip0`..`ip15`.
- `upd_done` out 1: one-cycle pulse when a counter write occurs.
- `upd_mispredict` out 1: qualified by `upd_done`; the pre-update counter MSB differed from `upd_taken`.
- `mis_cnt` out 16: saturating count of mispredicted updates.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is the MSB.
- Next-value rule:
  - taken: +1, saturating at 11.
  - not taken: −1, saturating at 00.
  - No wrap is ever allowed: 11 + taken = 11, and 00 + not-taken = 00.
- FSM states: RUN and CLEAR.
  - RUN → CLEAR when `clear` = 1.
  - CLEAR → RUN after the write of entry ENTRIES−1.
- `upd_ready` = (state == RUN) && !`clear` && !`rst`.
- An update is accepted when `upd_valid` && `upd_ready`.
- Stage A registers `{idx, taken}` with a valid bit.
- Stage B (the cycle after stage A):
  - reads `ctr[idx_q]`;
  - computes the saturating next value and writes it;
  - pulses `upd_done`;
  - sets `upd_mispredict` = old MSB != `taken_q`;
  - increments `mis_cnt` if mispredicted, saturating at 16'hFFFF.
- Back-to-back updates to the same index:
  - Each stage-B read sees the value written by the previous stage B, so no forwarding is needed.
  - N consecutive taken updates from 00 end at min(N, 3).
- CLEAR sweep:
  - A 4-bit sweep pointer starts at 0.
  - Each cycle it writes `INIT_CTR` to one entry, 0 through 15, taking 16 cycles.
  - `mis_cnt` is zeroed in the first CLEAR cycle.
  - `clear_busy` = 1 throughout.
- `clear` has priority over an update in the same cycle; that update is not accepted.
- When `clear` is taken, any stage-A item in flight is discarded: no write, no `upd_done`.
- `clear` asserted while already in CLEAR is ignored; the sweep does not restart.
- Reset, in any state including mid-sweep or mid-update:
  - all counters = `INIT_CTR`, state = RUN, pipeline valid = 0;
  - `upd_done` = 0, `upd_mispredict` = 0, `mis_cnt` = 0, `clear_busy` = 0;
  - `upd_ready` = 0 while `rst` is high.

## Timing
- Update accepted in cycle N:
  - stage A is registered at the end of N;
  - the counter is written at the end of N+1;
  - `upd_done`/`upd_mispredict` are high in N+1;
  - the new value appears on `ctrX` in N+2.
- Throughput: one update per cycle in RUN.
- Clear asserted in cycle N:
  - `clear_busy` and CLEAR state are high from N+1 through N+16;
  - entry k is reinitialised at the end of N+1+k;
  - `upd_ready` rises in N+17.
- All outputs except `upd_ready` are registered. `upd_ready` is combinational from state, `clear` and `rst`.

## Structure
- Shared package `bht_pkg`:
  - `CTR_W` = 2, `ENTRIES`, `IDX_W`;
  - counter encodings `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`;
  - FSM state encodings `ST_RUN`/`ST_CLEAR`.
- One sub-module, `bht_sat_next`: combinational; takes 2-bit counter and taken, produces the next counter value. The predictor's training path reuses it.
- Table storage is 16 × 2-bit flops, not RAM, so all entries drive the read mux in parallel.

## Test plan
- Reset, then taken ×4 to idx 3: `ctr3` goes 01→10→11→11, each value appearing 2 cycles after acceptance; `mis_cnt` = 1 (only the first update, old MSB 0).
- Not-taken ×3 to idx 15 from 01: `ctr15` = 00 and stays at 00; other entries unchanged; `upd_done` pulses 3 times.
- Alternating idx 5/6 updates at full rate: `upd_ready` stays 1, one write per cycle, no dropped updates.
- `clear` together with `upd_valid` to idx 0 while idx 2 is in stage A: neither update is written; after 16 cycles all `ctr` = 01 and `mis_cnt` = 0; `upd_ready` returns in cycle N+17.
- Drive `mis_cnt` to 16'hFFFF with forced mispredicts, then one more mispredict: `mis_cnt` holds at 16'hFFFF.
- `rst` asserted during cycle 7 of a clear sweep: the next cycle shows state RUN, `clear_busy` = 0, all counters = 01, `upd_ready` = 1.
